// File: rtl/bomberman_pkg.sv
// Shared types and constants for the player life bookkeeping and the life-bar renderer.
// No logic; the renderer derives its 50% colour threshold from LIFE_MAX_DEFAULT.
// Winner codes are bit-coded: bit0 = player 2 dead, bit1 = player 1 dead.
package bomberman_pkg;

  localparam int LIFE_MAX_DEFAULT = 100;

  typedef logic [6:0] life_t;

  typedef enum logic {
    RUN  = 1'b0,
    OVER = 1'b1
  } game_state_t;

  typedef logic [1:0] winner_t;

  localparam winner_t WIN_NONE = 2'b00;
  localparam winner_t WIN_P1   = 2'b01;
  localparam winner_t WIN_P2   = 2'b10;
  localparam winner_t WIN_DRAW = 2'b11;

  // Winner code from the two lives; WIN_NONE while both are still alive.
  function automatic winner_t winner_code(input life_t l1, input life_t l2);
    winner_t w;
    w = WIN_NONE;
    if (l1 == '0 && l2 == '0) w = WIN_DRAW;
    else if (l2 == '0)        w = WIN_P1;
    else if (l1 == '0)        w = WIN_P2;
    return w;
  endfunction

endpackage

// File: rtl/life_manager_if.sv
// Frame/hit/restart strobes in, life bar and game status out.
// Pure wiring; the master drives the strobes, the slave (life_manager) drives the status.
// No backpressure: every strobe is a single-cycle pulse.
interface life_manager_if;
  import bomberman_pkg::*;

  logic    frame_tick;
  logic    hit1;
  logic    hit2;
  logic    new_game;
  life_t   life1;
  life_t   life2;
  logic    invuln1;
  logic    invuln2;
  logic    game_over;
  winner_t winner;

  modport master (
    output frame_tick, hit1, hit2, new_game,
    input  life1, life2, invuln1, invuln2, game_over, winner
  );

  modport slave (
    input  frame_tick, hit1, hit2, new_game,
    output life1, life2, invuln1, invuln2, game_over, winner
  );

endinterface

// File: rtl/life_manager_player.sv
// One player's life: pending hit, saturating life, invulnerability and regen counters.
// Latency: frame tick at T updates life/invuln at T+1; hits are buffered until the next tick.
// No backpressure: hits while invulnerable or disabled are dropped, repeats in a frame collapse.
module life_player
  import bomberman_pkg::*;
#(
  parameter int LIFE_MAX      = LIFE_MAX_DEFAULT,
  parameter int DAMAGE        = 25,
  parameter int INVULN_FRAMES = 60,
  parameter int REGEN_FRAMES  = 120
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  restart,
  input  logic  tick,
  input  logic  hit,
  output life_t life,
  output logic  invuln
);

  localparam life_t      LMAX       = life_t'(LIFE_MAX);
  localparam life_t      DMG        = life_t'(DAMAGE);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [9:0] REGEN_LAST = 10'(REGEN_FRAMES - 1);
  localparam bit         REGEN_ON   = (REGEN_FRAMES != 0);

  life_t      life_q, life_d;
  logic [7:0] inv_q, inv_d;
  logic [9:0] regen_q, regen_d;
  logic       pend_q, pend_d;
  logic       hit_ok;

  assign hit_ok = hit && (inv_q == '0);

  // Next-state: restart, then tick-time damage/invuln/regen, else hit buffering.
  always_comb begin
    life_d  = life_q;
    inv_d   = inv_q;
    regen_d = regen_q;
    pend_d  = pend_q;
    if (restart) begin
      life_d  = LMAX;
      inv_d   = '0;
      regen_d = '0;
      pend_d  = 1'b0;
    end else if (en) begin
      if (tick) begin
        if (pend_q) begin
          // A hit arriving on the applying tick belongs to the same frame and is absorbed.
          life_d  = (life_q <= DMG) ? '0 : life_q - DMG;
          inv_d   = INV_LOAD;
          regen_d = '0;
          pend_d  = 1'b0;
        end else begin
          // A hit coincident with the tick waits for the following tick.
          pend_d = hit_ok;
          regen_d = '0;
          if (inv_q != '0) begin
            inv_d = inv_q - 8'd1;
          end else if (REGEN_ON && life_q != '0 && life_q < LMAX) begin
            if (regen_q == REGEN_LAST) begin
              life_d = life_q + 7'd1;
            end else begin
              regen_d = regen_q + 10'd1;
            end
          end
        end
      end else begin
        pend_d = pend_q | hit_ok;
      end
    end
  end

  // Player state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      life_q  <= LMAX;
      inv_q   <= '0;
      regen_q <= '0;
      pend_q  <= 1'b0;
      invuln  <= 1'b0;
    end else begin
      life_q  <= life_d;
      inv_q   <= inv_d;
      regen_q <= regen_d;
      pend_q  <= pend_d;
      invuln  <= (inv_d != '0);
    end
  end

  assign life = life_q;

endmodule

// File: rtl/life_manager.sv
// Two-player life bookkeeping with frame-aligned damage and end-of-game detection.
// Latency: tick at T -> lives at T+1 -> game_over/winner at T+2; new_game takes effect next cycle.
// No backpressure: all inputs are single-cycle pulses; OVER ignores everything but new_game.
module life_manager
  import bomberman_pkg::*;
#(
  parameter int LIFE_MAX      = LIFE_MAX_DEFAULT,
  parameter int DAMAGE        = 25,
  parameter int INVULN_FRAMES = 60,
  parameter int REGEN_FRAMES  = 120
) (
  input logic           clk,
  input logic           reset,
  life_manager_if.slave bus
);

  game_state_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic        game_over_q, game_over_d;
  life_t       life1, life2;
  logic        invuln1, invuln2;
  logic        en;
  logic        any_dead;

  assign en       = (state_q == RUN);
  assign any_dead = (life1 == '0) || (life2 == '0);

  life_player #(
    .LIFE_MAX(LIFE_MAX), .DAMAGE(DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
  ) u_p1 (
    .clk(clk), .reset(reset), .en(en), .restart(bus.new_game),
    .tick(bus.frame_tick), .hit(bus.hit1), .life(life1), .invuln(invuln1)
  );

  life_player #(
    .LIFE_MAX(LIFE_MAX), .DAMAGE(DAMAGE),
    .INVULN_FRAMES(INVULN_FRAMES), .REGEN_FRAMES(REGEN_FRAMES)
  ) u_p2 (
    .clk(clk), .reset(reset), .en(en), .restart(bus.new_game),
    .tick(bus.frame_tick), .hit(bus.hit2), .life(life2), .invuln(invuln2)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next state: a dead player ends the game one cycle after the life update; new_game always restarts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (!bus.new_game && any_dead) state_d = OVER;
      OVER:    if (bus.new_game) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (bus.new_game) state_d = RUN;
  end

  // Output decode: winner latched on the RUN->OVER transition, cleared on restart.
  always_comb begin
    winner_d    = winner_q;
    game_over_d = (state_d == OVER);
    if (bus.new_game) begin
      winner_d = WIN_NONE;
    end else if (state_q == RUN && state_d == OVER) begin
      winner_d = winner_code(life1, life2);
    end
  end

  // Registered game status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      winner_q    <= WIN_NONE;
      game_over_q <= 1'b0;
    end else begin
      winner_q    <= winner_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.life1     = life1;
  assign bus.life2     = life2;
  assign bus.invuln1   = invuln1;
  assign bus.invuln2   = invuln2;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_life_manager.sv
// Directed bench for life_manager: a vector table for the first hits, then hand sequences
// for invulnerability expiry, regeneration, game over, draw, reset and restart priority.
// Inputs change on the falling edge; outputs are sampled on the falling edge after the active edge.
module tb_life_manager;
  import bomberman_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  life_manager_if bus ();

  life_manager #(
    .LIFE_MAX(100), .DAMAGE(25), .INVULN_FRAMES(60), .REGEN_FRAMES(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic  t, h1, h2, ng, r;
    int    l1, l2, i1, i2, go, w;
    string name;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int l1, input int l2, input int i1,
                         input int i2, input int go, input int w);
    chk({name, ".life1"},     int'(bus.life1),     l1);
    chk({name, ".life2"},     int'(bus.life2),     l2);
    chk({name, ".invuln1"},   int'(bus.invuln1),   i1);
    chk({name, ".invuln2"},   int'(bus.invuln2),   i2);
    chk({name, ".game_over"}, int'(bus.game_over), go);
    chk({name, ".winner"},    int'(bus.winner),    w);
  endtask

  // One clock cycle with the given strobes; returns on the next falling edge.
  task automatic drive(input logic t, input logic h1, input logic h2, input logic ng,
                       input logic r);
    bus.frame_tick = t;
    bus.hit1       = h1;
    bus.hit2       = h2;
    bus.new_game   = ng;
    reset          = r;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    bus.hit1       = 1'b0;
    bus.hit2       = 1'b0;
    bus.new_game   = 1'b0;
    reset          = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      drive(1, 0, 0, 0, 0);
      repeat (3) drive(0, 0, 0, 0, 0);
    end
  endtask

  // Tick frames until both selected players are vulnerable again; an expired bound is a failure.
  task automatic wait_vuln(input bit p1, input bit p2);
    int n;
    n = 0;
    while (((p1 && bus.invuln1) || (p2 && bus.invuln2)) && n < 100) begin
      frames(1);
      n++;
    end
    chk("wait_vuln_bound", int'(n < 100), 1);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 100, 100, 0, 0, 0, 0, "hit1_pending"};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  75, 100, 1, 0, 0, 0, "hit1_applied"};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  75, 100, 1, 0, 0, 0, "hit1_t2"};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  75, 100, 1, 0, 0, 0, "hit2_on_tick"};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  75, 100, 1, 0, 0, 0, "hit2_latched"};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  75, 100, 1, 0, 0, 0, "hit1_while_inv"};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  75,  75, 1, 1, 0, 0, "hit2_applied"};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  75,  75, 1, 1, 0, 0, "hit2_t2"};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  75,  75, 1, 1, 0, 0, "hit1_dropped"};

    bus.frame_tick = 1'b0;
    bus.hit1       = 1'b0;
    bus.hit2       = 1'b0;
    bus.new_game   = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    drive(0, 0, 0, 0, 1);
    chk_all("reset", 100, 100, 0, 0, 0, 0);
    frames(10);
    chk_all("idle10", 100, 100, 0, 0, 0, 0);

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].t, tbl[i].h1, tbl[i].h2, tbl[i].ng, tbl[i].r);
      chk_all(tbl[i].name, tbl[i].l1, tbl[i].l2, tbl[i].i1, tbl[i].i2, tbl[i].go, tbl[i].w);
    end

    // Three ticks since the hit1 tick; 56 more leave one frame of invulnerability.
    repeat (56) begin
      drive(1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0);
    end
    chk("inv1_tick59", int'(bus.invuln1), 1);
    drive(1, 0, 0, 0, 0);
    chk("inv1_tick60", int'(bus.invuln1), 0);
    chk("life1_hits_ignored", int'(bus.life1), 75);

    // Regeneration, period 4 frames; player 2 is two frames behind on invulnerability.
    frames(3);
    chk("regen_3", int'(bus.life1), 75);
    frames(1);
    chk("regen_4", int'(bus.life1), 76);
    chk("regen_p2_late", int'(bus.life2), 75);
    frames(95);
    chk("regen_99", int'(bus.life1), 99);
    frames(1);
    chk("regen_100", int'(bus.life1), 100);
    frames(8);
    chk("regen_cap1", int'(bus.life1), 100);
    chk("regen_cap2", int'(bus.life2), 100);

    drive(0, 0, 0, 1, 0);
    chk_all("new_game_run", 100, 100, 0, 0, 0, 0);

    // Player 2 driven to zero by four accepted hits.
    for (int k = 1; k <= 4; k++) begin
      wait_vuln(1'b0, 1'b1);
      drive(0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0);
      chk($sformatf("p2_hit%0d", k), int'(bus.life2), 100 - 25 * k);
    end
    chk_all("p2_dead_t1", 100, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_all("p2_dead_t2", 100, 0, 0, 1, 1, 1);
    drive(0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    frames(3);
    chk_all("over_frozen", 100, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 0);
    chk_all("new_game_over", 100, 100, 0, 0, 0, 0);

    // Simultaneous death.
    for (int k = 1; k <= 4; k++) begin
      wait_vuln(1'b1, 1'b1);
      drive(0, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 0);
      chk($sformatf("both_hit%0d_l1", k), int'(bus.life1), 100 - 25 * k);
      chk($sformatf("both_hit%0d_l2", k), int'(bus.life2), 100 - 25 * k);
    end
    drive(0, 0, 0, 0, 0);
    chk_all("draw", 0, 0, 1, 1, 1, 3);

    // Reset mid-frame with hits pending.
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk_all("reset_pending", 100, 100, 0, 0, 0, 0);
    frames(2);
    chk_all("no_late_damage", 100, 100, 0, 0, 0, 0);

    // Restart coincident with a tick: the tick and the pending hit are both dropped.
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    chk_all("ng_tick", 100, 100, 0, 0, 0, 0);
    frames(1);
    chk_all("ng_tick_after", 100, 100, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
